// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared types and constants for the two-requester ALU arbiter.
//   - state_e   : arbiter FSM states (IDLE, ISSUE, RESP)
//   - FLAG_*    : bit positions inside the 4-bit ALU flag vector
//   - req_id_t  : requester index (0 or 1)
//   - id_to_onehot : requester index -> one-hot 2-bit vector
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef logic req_id_t;

    function automatic logic [1:0] id_to_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter. A lone requester always wins; when both
//   request, the pointer picks the winner. On 'advance' (the grant was taken)
//   the pointer moves to the requester that did not win.
// Ports:
//   clk, reset   clock, asynchronous active-low reset (pointer -> requester 0)
//   req[1:0]     request vector, bit i = requester i
//   advance      grant accepted this cycle
//   grant[1:0]   one-hot grant (all-zero when nobody requests)
//   ptr          current pointer (preferred requester on contention)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output req_id_t    ptr
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = id_to_onehot(ptr_q);
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && (grant != 2'b00)) begin
            ptr_d = ~grant[1];
        end
    end

    // NOTE: asynchronous reset lives in the sensitivity list; state updates use
    // non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one registered ALU between two requesters. One operation is in
//   flight at a time: IDLE accepts a request (round-robin on contention),
//   ISSUE holds the operands for LAT cycles, RESP presents the captured
//   result/flags to the owner until it accepts.
// Parameters:
//   N    operand/result width
//   LAT  cycles from alu_a/alu_b/alu_sel driven to valid alu_out/alu_flags (>=1)
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake, bit i = requester i
//   a0,b0,sel0 / a1,b1,sel1  requester operands and ALU select
//   rsp_valid/rsp_ready   response handshake, rsp_valid one-hot to owner
//   rsp_data, rsp_flags   captured ALU result and flags {V,N,Z,C}
//   alu_a, alu_b, alu_sel operands to the ALU (held between operations)
//   alu_out, alu_flags    ALU result and flags
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [3:0]   sel0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic [3:0]   sel1,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic [3:0]   rsp_flags,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_out,
    input  logic [3:0]   alu_flags
);

    // Counter only ever holds LAT-1 down to 0.
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    state_e        state_q, state_d;
    req_id_t       owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  alu_a_q, alu_a_d;
    logic [N-1:0]  alu_b_q, alu_b_d;
    logic [3:0]    alu_sel_q, alu_sel_d;
    logic [N-1:0]  rsp_data_q, rsp_data_d;
    logic [3:0]    rsp_flags_q, rsp_flags_d;
    // Clears on reset and sets on the first clock after release, keeping
    // req_ready low while reset is asserted even though the state is IDLE.
    logic          active_q, active_d;

    logic [1:0]    grant;
    req_id_t       ptr;
    logic          accept;
    req_id_t       winner;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .ptr     (ptr)
    );

    assign req_ready = (state_q == IDLE && active_q) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    // On contention the pointer names the winner; otherwise the lone requester.
    assign winner    = (req_valid == 2'b11) ? ptr : grant[1];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        active_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d   = winner;
                    alu_a_d   = winner ? a1   : a0;
                    alu_b_d   = winner ? b1   : b0;
                    alu_sel_d = winner ? sel1 : sel0;
                    cnt_d     = CNT_LOAD;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_out;
                    rsp_flags_d = alu_flags;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Only the owner's rsp_ready can complete the response.
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= 4'h0;
            rsp_data_q  <= '0;
            rsp_flags_q <= 4'h0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            active_q    <= active_d;
        end
    end

    assign rsp_valid = (state_q == RESP) ? id_to_onehot(owner_q) : 2'b00;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;

endmodule
